// File: rtl/accum_tile_drain_pkg.sv
// Shared complex sample and tile types for the accumulator output path.
// The optional sequence tag width is also defined here; it is only used when ACCUM_DRAIN_SEQ_EN is defined.
package accum_tile_drain_pkg;

  localparam int DATA_W   = 16;
  localparam int TILE_DIM = 4;
  localparam int ROW_W    = $clog2(TILE_DIM);
  localparam int SEQ_W    = 8;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_t;

  typedef complex_t [0:TILE_DIM-1]              complex_row_t;
  typedef complex_t [0:TILE_DIM-1][0:TILE_DIM-1] complex_tile_t;

endpackage

// File: rtl/accum_tile_drain_fifo.sv
// drain_tile_fifo: tile storage with pointers, occupancy and sticky overflow.
// ACCUM_DRAIN_SEQ_EN adds a per-tile sequence tag stored beside each tile.
module drain_tile_fifo
  import accum_tile_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  complex_tile_t        push_tile,
`ifdef ACCUM_DRAIN_SEQ_EN
  input  logic [SEQ_W-1:0]     push_seq,
  output logic [SEQ_W-1:0]     head_seq,
`endif
  input  logic                 pop_tile,
  input  logic [ROW_W-1:0]     row_sel,
  output complex_row_t         head_row,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 overflow,
  output logic                 empty
);

  complex_tile_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             accept;
  logic             drop;

  assign empty  = (occupancy == '0);
  assign full   = (occupancy == CNT_W'(DEPTH));
  assign pop_ok = pop_tile && !empty;
  // A tile-completing pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign accept = push && (!full || pop_ok);
  assign drop   = push && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop_ok})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_tile;
  end

  assign head_row = mem[rd_ptr][row_sel];

`ifdef ACCUM_DRAIN_SEQ_EN
  logic [SEQ_W-1:0] seq_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) seq_mem[wr_ptr] <= push_seq;
  end

  assign head_seq = seq_mem[rd_ptr];
`endif

endmodule

// File: rtl/accum_tile_drain.sv
// accum_tile_drain: buffers 4x4 accumulator tiles and streams them out one row per handshake.
// ACCUM_DRAIN_SEQ_EN adds out_seq, the tag of the tile being drained (counts every in_valid pulse).
module accum_tile_drain
  import accum_tile_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  complex_tile_t      in_tile,
  input  logic               in_valid,
  output complex_row_t       out_row,
  output logic [ROW_W-1:0]   out_row_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   occupancy,
  output logic               overflow
`ifdef ACCUM_DRAIN_SEQ_EN
  ,
  output logic [SEQ_W-1:0]   out_seq
`endif
);

  logic [ROW_W-1:0] row_cnt;
  logic             transfer;
  logic             pop_tile;
  logic             empty;

  assign out_valid   = !empty;
  assign transfer    = out_valid && out_ready;
  assign out_last    = (row_cnt == ROW_W'(TILE_DIM - 1));
  assign pop_tile    = transfer && out_last;
  assign out_row_idx = row_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
    end else if (transfer) begin
      row_cnt <= row_cnt + ROW_W'(1);
    end
  end

`ifdef ACCUM_DRAIN_SEQ_EN
  logic [SEQ_W-1:0] seq_cnt;

  // Dropped tiles still consume a tag so downstream sees the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_cnt <= '0;
    end else if (in_valid) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end
`endif

  drain_tile_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .push_tile(in_tile),
`ifdef ACCUM_DRAIN_SEQ_EN
    .push_seq (seq_cnt),
    .head_seq (out_seq),
`endif
    .pop_tile (pop_tile),
    .row_sel  (row_cnt),
    .head_row (out_row),
    .occupancy(occupancy),
    .overflow (overflow),
    .empty    (empty)
  );

endmodule

// File: tb/tb_accum_tile_drain.sv
// Directed self-checking bench for accum_tile_drain (DEPTH=4); with ACCUM_DRAIN_SEQ_EN
// a second DEPTH=2 instance exercises the sequence tags.
module tb_accum_tile_drain;
  import accum_tile_drain_pkg::*;

  logic          clk;
  logic          reset;
  complex_tile_t in_tile;
  logic          in_valid;
  complex_row_t  out_row;
  logic [1:0]    out_row_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    occupancy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

`ifdef ACCUM_DRAIN_SEQ_EN
  logic [SEQ_W-1:0] out_seq;

  logic             s_reset;
  complex_tile_t    s_in_tile;
  logic             s_in_valid;
  complex_row_t     s_out_row;
  logic [1:0]       s_out_row_idx;
  logic             s_out_last;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [1:0]       s_occupancy;
  logic             s_overflow;
  logic [SEQ_W-1:0] s_out_seq;
`endif

  accum_tile_drain #(.DEPTH(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_tile    (in_tile),
    .in_valid   (in_valid),
    .out_row    (out_row),
    .out_row_idx(out_row_idx),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .overflow   (overflow)
`ifdef ACCUM_DRAIN_SEQ_EN
    ,
    .out_seq    (out_seq)
`endif
  );

`ifdef ACCUM_DRAIN_SEQ_EN
  accum_tile_drain #(.DEPTH(2)) u_dut2 (
    .clk        (clk),
    .reset      (s_reset),
    .in_tile    (s_in_tile),
    .in_valid   (s_in_valid),
    .out_row    (s_out_row),
    .out_row_idx(s_out_row_idx),
    .out_last   (s_out_last),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .occupancy  (s_occupancy),
    .overflow   (s_overflow),
    .out_seq    (s_out_seq)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element [i][j] of a tile with offset base is {base+i*4+j, -(base+i*4+j)}.
  function automatic complex_tile_t make_tile(input int base);
    complex_tile_t t;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        t[i][j].re = 16'(base + i * 4 + j);
        t[i][j].im = 16'(-(base + i * 4 + j));
      end
    end
    return t;
  endfunction

  function automatic complex_row_t make_row(input int base, input int r);
    complex_row_t row;
    for (int j = 0; j < 4; j++) begin
      row[j].re = 16'(base + r * 4 + j);
      row[j].im = 16'(-(base + r * 4 + j));
    end
    return row;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || overflow !== 1'b0 || out_row_idx !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b occ=%0d ovf=%b idx=%0d, expected 0 0 0 0",
               out_valid, occupancy, overflow, out_row_idx);
    end
  endtask

  task automatic test_single_tile();
    in_tile = make_tile(0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pre_valid: valid=%b, expected 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_last !== (r == 3) ||
          occupancy !== 3'd1 || out_row !== make_row(0, r)) begin
        errors++;
        $display("[TB] FAIL single_beat%0d: valid=%b idx=%0d last=%b occ=%0d row=%h, expected 1 %0d %b 1 %h",
                 r, out_valid, out_row_idx, out_last, occupancy, out_row, r, (r == 3), make_row(0, r));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("[TB] FAIL single_empty: valid=%b occ=%0d, expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_tile = make_tile(100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_tile = make_tile(7000);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row_idx !== 2'd0 || out_last !== 1'b0 || out_row !== make_row(100, 0)) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%b idx=%0d last=%b row=%h, expected 1 0 0 %h",
                 c, out_valid, out_row_idx, out_last, out_row, make_row(100, 0));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_row !== make_row(100, r)) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: valid=%b idx=%0d row=%h, expected 1 %0d %h",
                 r, out_valid, out_row_idx, out_row, r, make_row(100, r));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_empty: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_tile = make_tile(256 * (k + 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_state: occ=%0d ovf=%b, expected 4 1", occupancy, overflow);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_row !== make_row(256 * (t + 1), r)) begin
          errors++;
          $display("[TB] FAIL ovf_tile%0d_row%0d: valid=%b idx=%0d row=%h, expected 1 %0d %h",
                   t, r, out_valid, out_row_idx, out_row, r, make_row(256 * (t + 1), r));
        end
        tick();
      end
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_after: valid=%b ovf=%b, expected 0 1 (fifth tile absent, sticky flag)",
               out_valid, overflow);
    end
  endtask

  task automatic test_full_boundary();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_tile = make_tile(2000 + 100 * k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_pre: occ=%0d ovf=%b, expected 4 0", occupancy, overflow);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) tick();
    checks++;
    if (out_row_idx !== 2'd3 || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_last_row: idx=%0d last=%b, expected 3 1", out_row_idx, out_last);
    end
    in_tile = make_tile(2400);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4 || overflow !== 1'b0 || out_row_idx !== 2'd0 || out_row !== make_row(2100, 0)) begin
      errors++;
      $display("[TB] FAIL full_same_cycle: occ=%0d ovf=%b idx=%0d row=%h, expected 4 0 0 %h",
               occupancy, overflow, out_row_idx, out_row, make_row(2100, 0));
    end
    for (int t = 1; t < 5; t++) begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_row !== make_row(2000 + 100 * t, r)) begin
          errors++;
          $display("[TB] FAIL full_tile%0d_row%0d: valid=%b idx=%0d row=%h, expected 1 %0d %h",
                   t, r, out_valid, out_row_idx, out_row, r, make_row(2000 + 100 * t, r));
        end
        tick();
      end
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drained: valid=%b occ=%0d ovf=%b, expected 0 0 0", out_valid, occupancy, overflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_tile = make_tile(3000 + 100 * k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_row_idx !== 2'd2 || overflow !== 1'b1 || occupancy !== 3'd4) begin
      errors++;
      $display("[TB] FAIL mid_pre: idx=%0d ovf=%b occ=%0d, expected 2 1 4", out_row_idx, overflow, occupancy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || overflow !== 1'b0 || out_row_idx !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b occ=%0d ovf=%b idx=%0d, expected 0 0 0 0",
               out_valid, occupancy, overflow, out_row_idx);
    end
    in_tile = make_tile(3500);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row_idx !== 2'(r) || out_row !== make_row(3500, r)) begin
        errors++;
        $display("[TB] FAIL mid_new_beat%0d: valid=%b idx=%0d row=%h, expected 1 %0d %h",
                 r, out_valid, out_row_idx, out_row, r, make_row(3500, r));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_empty: valid=%b, expected 0", out_valid);
    end
  endtask

`ifdef ACCUM_DRAIN_SEQ_EN
  task automatic test_seq_tags();
    s_reset = 1'b1;
    s_in_valid = 1'b0;
    s_out_ready = 1'b0;
    tick();
    s_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_in_tile = make_tile(4000 + 100 * k);
      s_in_valid = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
    checks++;
    if (s_occupancy !== 2'd2 || s_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seq_full: occ=%0d ovf=%b, expected 2 1", s_occupancy, s_overflow);
    end
    s_out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_seq !== 8'(t) || s_out_row !== make_row(4000 + 100 * t, r)) begin
          errors++;
          $display("[TB] FAIL seq_tile%0d_row%0d: valid=%b seq=%0d row=%h, expected 1 %0d %h",
                   t, r, s_out_valid, s_out_seq, s_out_row, t, make_row(4000 + 100 * t, r));
        end
        tick();
      end
    end
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_dropped: valid=%b, expected 0 (tag 2 dropped)", s_out_valid);
    end
    for (int k = 0; k < 254; k++) begin
      s_in_tile = make_tile(k);
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_out_valid !== 1'b1 || s_out_seq !== 8'(3 + k)) begin
        errors++;
        $display("[TB] FAIL seq_wrap%0d: valid=%b seq=%0d, expected 1 %0d", k, s_out_valid, s_out_seq, (3 + k) % 256);
      end
      repeat (4) tick();
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_tile = '0;
`ifdef ACCUM_DRAIN_SEQ_EN
    s_reset = 1'b1;
    s_in_valid = 1'b0;
    s_out_ready = 1'b0;
    s_in_tile = '0;
`endif
    tick();
    test_reset();
    test_single_tile();
    test_backpressure();
    test_overflow();
    test_full_boundary();
    test_reset_mid_drain();
`ifdef ACCUM_DRAIN_SEQ_EN
    test_seq_tags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_tile_drain.md
Name: accum_tile_drain

Overview:
Drains 4x4 complex result tiles from the accumulator array, which pulses output_valid once per finished tile and cannot be stalled. Each tile is captured into a small tile FIFO. Tiles are then serialized one row (4 complex_t) per beat to downstream logic (IFFT / writeback) over a valid/ready handshake. It sits between complexAccumulatorArrayParallel and the output path.

Parameters:
DEPTH, 4, tile FIFO capacity in tiles; power of 2, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_tile  input  complex_t [0:3][0:3]  accumulator result tile
in_valid  input  1  one-cycle pulse; in_tile valid this cycle (connect to accumulator output_valid)
out_row  output  complex_t [0:3]  current row, element j = tile[row][j]
out_row_idx  output  2  row index 0..3 of out_row
out_last  output  1  high when out_row_idx==3
out_valid  output  1  row available
out_ready  input  1  downstream accepts row
occupancy  output  CNT_W  tiles held, including a partially drained tile
overflow  output  1  sticky; a tile was dropped

Behaviour:
- Reset: a synchronous, active-high reset clears wr_ptr, rd_ptr, occupancy, row_cnt and overflow to 0, so out_valid=0 and out_row_idx=0. Storage is not reset, so out_row is don't-care while out_valid=0. Reset mid-drain discards all held tiles. No partial row may appear after reset.
- Capture: at the edge where in_valid=1 and the FIFO is not full, in_tile is written at wr_ptr, wr_ptr advances (mod DEPTH) and occupancy increments.
- Full: with in_valid=1 and occupancy==DEPTH and no tile-completing pop in the same cycle, the tile is dropped, overflow is set to 1 (sticky until reset) and pointers are unchanged.
- Simultaneous capture and final-row pop when full: the capture is accepted and occupancy is unchanged.
- Output: out_valid = (occupancy != 0). out_row = mem[rd_ptr][row_cnt], a combinational read of registered storage.
- Latency: a captured tile is visible on out_valid the cycle after the in_valid edge, with out_row_idx=0.
- Handshake: a transfer occurs when out_valid && out_ready. On a transfer row_cnt increments. When row_cnt==3 it wraps to 0, rd_ptr advances and occupancy decrements.
- out_row, out_row_idx and out_last stay stable while out_valid && !out_ready. out_valid never drops without a transfer, except on reset.
- Throughput: 1 row/cycle, so 4 cycles per tile. Sustained accumulator rate must be <= 1 tile per 4 cycles to avoid drops.
- Empty: out_ready with out_valid=0 has no effect.
- Pointer wrap: pointers wrap at DEPTH. Full/empty are decided by occupancy, not pointer equality.

Optional Feature:
Macro ACCUM_DRAIN_SEQ_EN.
- With the macro defined: add an 8-bit output out_seq, the sequence tag of the tile being drained. An internal 8-bit seq counter (reset 0) increments on every in_valid pulse, including dropped tiles. The tag is stored alongside each accepted tile, so downstream detects drops as gaps. The counter wraps 255->0.
- Without the macro: no out_seq port, no tag storage.

Decomposition:
- complex_t stays in the shared common package.
- Add to that package: TILE_DIM=4, typedef complex_tile_t = complex_t [0:TILE_DIM-1][0:TILE_DIM-1], typedef complex_row_t = complex_t [0:TILE_DIM-1].
- One sub-module, drain_tile_fifo: storage, pointers, occupancy, and the full/empty/overflow logic with a pop-tile input.
- The top level holds row_cnt, the handshake and the optional seq tag.

Test Plan:
- Single tile, element [i][j] = {real=i*4+j, imag=-(i*4+j)}, out_ready=1: out_valid rises 1 cycle after in_valid. 4 consecutive beats carry rows 0..3, with out_last only on beat 4. Occupancy goes 1->0.
- Backpressure: hold out_ready=0 for 10 cycles after a capture. out_row and out_row_idx=0 stay constant. Release; all 4 rows drain in order.
- Overflow, DEPTH=4, out_ready=0, 5 in_valid pulses: occupancy=4, overflow=1. Drained data equals tiles 1-4; tile 5 is absent.
- Full boundary: occupancy=4 with the final row of the head tile handshaking in the same cycle as in_valid. Tile accepted, overflow stays 0, occupancy stays 4.
- Reset mid-drain after row 1: next cycle out_valid=0, occupancy=0, overflow=0. A new tile then drains starting at row 0.
- ACCUM_DRAIN_SEQ_EN, DEPTH=2, out_ready=0, 3 pulses: drained out_seq = 0, 1; the tile tagged 2 is dropped. Then 254 further pulses with out_ready=1 show the counter wrapping 255->0.
